// File: rtl/swipt_fsk_modulator.sv
// FSK modulator for the SWIPT bridge PWM: frames bytes as start/data/stop symbols on the carrier period.
// Optional macro SWIPT_FSK_PARITY_EN adds an even-parity bit between DATA and STOP.
//
// state  | meaning
// OFF    | carrier disabled, period parked at F0
// IDLE   | F0 carrier running, ready for a byte
// WAIT   | byte latched, waiting for the next carrier boundary
// START  | start symbol (F1)
// DATA   | 8 data symbols, LSB first
// PARITY | even parity symbol (SWIPT_FSK_PARITY_EN only)
// STOP   | stop symbol (F0)
module swipt_fsk_modulator #(
  parameter int F0_PERIOD      = 200,
  parameter int F1_PERIOD      = 180,
  parameter int CYCLES_PER_BIT = 64
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_power_en,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [31:0] o_freq,
  output logic        o_enable,
  output logic        o_busy,
  output logic        o_period_tick
);

  localparam int CW = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [31:0]   F0       = 32'(F0_PERIOD);
  localparam logic [31:0]   F1       = 32'(F1_PERIOD);
  localparam logic [CW-1:0] BIT_LAST = CW'(CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
`ifdef SWIPT_FSK_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t        state;
  logic [31:0]   phase;
  logic [31:0]   phase_inc;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          boundary;
  logic          bit_done;
`ifdef SWIPT_FSK_PARITY_EN
  logic          parity_bit;
`endif

  function automatic logic [31:0] sym_period(input logic b);
    return b ? F1 : F0;
  endfunction

  // Phase tracks the PWM counter so period updates land exactly on its wrap edge.
  assign phase_inc = phase + 32'd1;
  assign boundary  = o_enable && (phase_inc >= o_freq);
  assign bit_done  = boundary && (bit_cnt == BIT_LAST);
  assign o_ready   = (state == ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state         <= ST_OFF;
      o_freq        <= F0;
      o_enable      <= 1'b0;
      o_busy        <= 1'b0;
      o_period_tick <= 1'b0;
      phase         <= 32'd0;
      bit_cnt       <= '0;
      bit_idx       <= 4'd0;
      shreg         <= 8'd0;
`ifdef SWIPT_FSK_PARITY_EN
      parity_bit    <= 1'b0;
`endif
    end else if (!i_power_en) begin
      state         <= ST_OFF;
      o_freq        <= F0;
      o_enable      <= 1'b0;
      o_busy        <= 1'b0;
      o_period_tick <= 1'b0;
      phase         <= 32'd0;
      bit_cnt       <= '0;
      bit_idx       <= 4'd0;
    end else begin
      o_period_tick <= boundary;
      phase         <= (!o_enable || boundary) ? 32'd0 : phase_inc;

      // Counts carrier periods within the current symbol.
      if (state != ST_OFF && state != ST_IDLE && state != ST_WAIT && boundary)
        bit_cnt <= bit_done ? '0 : bit_cnt + CW'(1);

      case (state)
        ST_OFF: begin
          state    <= ST_IDLE;
          o_enable <= 1'b1;
          o_freq   <= F0;
          o_busy   <= 1'b0;
        end
        ST_IDLE: begin
          if (i_valid) begin
            shreg  <= i_data;
`ifdef SWIPT_FSK_PARITY_EN
            parity_bit <= ^i_data;
`endif
            state  <= ST_WAIT;
            o_busy <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (boundary) begin
            state   <= ST_START;
            o_freq  <= F1;
            bit_cnt <= '0;
          end
        end
        ST_START: begin
          if (bit_done) begin
            state   <= ST_DATA;
            bit_idx <= 4'd0;
            o_freq  <= sym_period(shreg[0]);
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            if (bit_idx == 4'd7) begin
`ifdef SWIPT_FSK_PARITY_EN
              state  <= ST_PARITY;
              o_freq <= sym_period(parity_bit);
`else
              state  <= ST_STOP;
              o_freq <= F0;
`endif
            end else begin
              bit_idx <= bit_idx + 4'd1;
              shreg   <= {1'b0, shreg[7:1]};
              o_freq  <= sym_period(shreg[1]);
            end
          end
        end
`ifdef SWIPT_FSK_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            state  <= ST_STOP;
            o_freq <= F0;
          end
        end
`endif
        ST_STOP: begin
          if (bit_done) begin
            state  <= ST_IDLE;
            o_freq <= F0;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state    <= ST_OFF;
          o_enable <= 1'b0;
          o_freq   <= F0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swipt_fsk_modulator.sv
// Self-checking bench for swipt_fsk_modulator with F0=20, F1=16, four carrier periods per bit.
module tb_swipt_fsk_modulator;

  localparam int F0  = 20;
  localparam int F1  = 16;
  localparam int CPB = 4;

  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic        i_power_en;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] o_freq;
  logic        o_enable;
  logic        o_busy;
  logic        o_period_tick;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  swipt_fsk_modulator #(
    .F0_PERIOD(F0),
    .F1_PERIOD(F1),
    .CYCLES_PER_BIT(CPB)
  ) dut (
    .i_clk(i_clk),
    .i_nrst(i_nrst),
    .i_power_en(i_power_en),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_freq(o_freq),
    .o_enable(o_enable),
    .o_busy(o_busy),
    .o_period_tick(o_period_tick)
  );

  // syms[0] is the start symbol, then data LSB first, then parity (if built in) and stop.
  typedef struct {
    logic [7:0]  data;
    logic [10:0] syms;
    int          nbits;
    int          d;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!o_period_tick && cnt < 64);
  endtask

  // One idle carrier period: length F0, period word steady at F0, no frame.
  task automatic idle_period(input string name);
    int cnt;
    int bad;
    cnt = 0;
    bad = 0;
    do begin
      step();
      cnt++;
      if (o_freq != 32'(F0) || o_busy) bad = 1;
    end while (!o_period_tick && cnt < 64);
    check({name, "_len"}, cnt, F0);
    check({name, "_steady"}, bad, 0);
  endtask

  task automatic send_frame(input vec_t v, input bit align, input bit hold, input logic [7:0] next_data);
    int c;
    int cnt;
    int bad;
    int exp;
    if (align) begin
      wait_tick(c);
      check("align_tick", int'(o_period_tick), 1);
      repeat (v.d) step();
    end
    i_valid = 1'b1;
    i_data  = v.data;
    step();
    i_valid = hold;
    i_data  = hold ? next_data : 8'h00;
    check("busy_rise", int'(o_busy), 1);
    check("ready_after_accept", int'(o_ready), 0);
    c   = 0;
    bad = 0;
    while (!o_period_tick && c < 64) begin
      if (o_freq != 32'(F0)) bad = 1;
      step();
      c++;
    end
    check("wait_to_boundary", c, 19 - v.d);
    check("wait_freq_steady", bad, 0);
    for (int b = 0; b < v.nbits; b++) begin
      for (int p = 0; p < CPB; p++) begin
        exp = v.syms[b] ? F1 : F0;
        check("sym_freq", int'(o_freq), exp);
        check("busy_frame", int'(o_busy), 1);
        check("ready_frame", int'(o_ready), 0);
        cnt = 0;
        bad = 0;
        do begin
          step();
          cnt++;
          if (!o_period_tick && o_freq != 32'(exp)) bad = 1;
        end while (!o_period_tick && cnt < 64);
        check("period_len", cnt, exp);
        check("freq_stable", bad, 0);
      end
    end
    check("busy_fall", int'(o_busy), 0);
    check("ready_idle", int'(o_ready), 1);
    check("idle_freq", int'(o_freq), F0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v2;
    int   c;
    i_nrst     = 1'b0;
    i_power_en = 1'b1;
    i_valid    = 1'b0;
    i_data     = 8'h00;

`ifdef SWIPT_FSK_PARITY_EN
    vecs[0] = '{data: 8'h07, syms: 11'b01000001111, nbits: 11, d: 3};
    vecs[1] = '{data: 8'hA5, syms: 11'b00101001011, nbits: 11, d: 0};
    vecs[2] = '{data: 8'hFF, syms: 11'b00111111111, nbits: 11, d: 18};
    vecs[3] = '{data: 8'h3C, syms: 11'b00001111001, nbits: 11, d: 10};
`else
    vecs[0] = '{data: 8'hA5, syms: 11'b00101001011, nbits: 10, d: 3};
    vecs[1] = '{data: 8'h00, syms: 11'b00000000001, nbits: 10, d: 0};
    vecs[2] = '{data: 8'hFF, syms: 11'b00111111111, nbits: 10, d: 18};
    vecs[3] = '{data: 8'h3C, syms: 11'b00001111001, nbits: 10, d: 10};
`endif

    // Reset overrides power enable.
    @(negedge i_clk);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_enable", int'(o_enable), 0);
      check("rst_freq", int'(o_freq), F0);
      check("rst_ready", int'(o_ready), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_tick", int'(o_period_tick), 0);
    end
    i_nrst = 1'b1;
    step();
    check("idle_enable", int'(o_enable), 1);
    check("idle_ready", int'(o_ready), 1);
    check("idle_busy", int'(o_busy), 0);
    idle_period("idle_first");
    idle_period("idle_second");

    for (int i = 0; i < 4; i++)
      send_frame(vecs[i], 1'b1, 1'b0, 8'h00);

    // Backpressure: second byte held through the first frame, taken on the first IDLE cycle.
    send_frame(vecs[0], 1'b1, 1'b1, vecs[3].data);
    v2   = vecs[3];
    v2.d = 0;
    send_frame(v2, 1'b0, 1'b0, 8'h00);

    // Abort during data bit 3 of 0xA5.
    wait_tick(c);
    i_valid = 1'b1;
    i_data  = 8'hA5;
    step();
    i_valid = 1'b0;
    i_data  = 8'h00;
    for (int k = 0; k < 17; k++) wait_tick(c);
    check("abort_bit3_freq", int'(o_freq), F0);
    check("abort_bit3_busy", int'(o_busy), 1);
    repeat (5) step();
    i_power_en = 1'b0;
    step();
    check("abort_enable", int'(o_enable), 0);
    check("abort_freq", int'(o_freq), F0);
    check("abort_busy", int'(o_busy), 0);
    check("abort_ready", int'(o_ready), 0);
    check("abort_tick", int'(o_period_tick), 0);
    repeat (3) step();
    check("off_enable", int'(o_enable), 0);
    check("off_tick", int'(o_period_tick), 0);
    i_power_en = 1'b1;
    step();
    check("repower_enable", int'(o_enable), 1);
    check("repower_ready", int'(o_ready), 1);
    check("repower_busy", int'(o_busy), 0);
    check("repower_freq", int'(o_freq), F0);
    idle_period("repower_first");
    idle_period("repower_second");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
